// File: rtl/ov_7670_frame_reader.sv
// rtl/ov_7670_frame_reader.sv - raster-order frame-buffer reader with VGA-style timing
module ov_7670_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [18:0] rd_addr,
    output logic        rd_en,
    input  logic [23:0] rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Flag bundle carried down the delay line: {visible, hsync, vsync, frame_start}
    localparam logic [3:0] FLAGS_IDLE = 4'b0110;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [18:0]   addr_cnt;
    logic          visible;
    logic          hsync_raw;
    logic          vsync_raw;
    logic          first_pixel;
    logic          line_end;
    logic          frame_end;
    logic [3:0]    flags [RD_LAT];
    logic [3:0]    tap;

    // Stage-0 decode of the raster position
    always_comb begin
        visible     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hsync_raw   = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
        vsync_raw   = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
        first_pixel = (h_cnt == '0) && (v_cnt == '0);
        line_end    = (h_cnt == HW'(H_TOTAL - 1));
        frame_end   = line_end && (v_cnt == VW'(V_TOTAL - 1));
        tap         = flags[RD_LAT-1];
    end

    // Raster counters and running pixel address; held at the origin while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else if (!enable) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            if (frame_end) begin
                addr_cnt <= '0;
            end else if (visible) begin
                addr_cnt <= addr_cnt + 19'd1;
            end
        end
    end

    // Read request; address holds between lines so it never leaves the frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else if (!enable) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en <= visible;
            if (visible) begin
                rd_addr <= addr_cnt;
            end
        end
    end

    // Timing flags delayed RD_LAT clocks so they line up with rd_data; drains when disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                flags[i] <= FLAGS_IDLE;
            end
        end else begin
            flags[0] <= enable ? {visible, hsync_raw, vsync_raw, visible && first_pixel} : FLAGS_IDLE;
            for (int i = 1; i < RD_LAT; i++) begin
                flags[i] <= flags[i-1];
            end
        end
    end

    // Output register: colour only when the aligned pixel is visible, otherwise black
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_n     <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            blank_n              <= tap[3];
            hsync                <= tap[2];
            vsync                <= tap[1];
            frame_start          <= tap[0];
            {red, green, blue}   <= tap[3] ? rd_data : 24'h0;
        end
    end

endmodule

// File: tb/tb_ov_7670_frame_reader.sv
// tb/tb_ov_7670_frame_reader.sv - randomized self-checking bench for ov_7670_frame_reader
module tb_ov_7670_frame_reader;

    localparam int SH_A = 16, SH_FP = 3, SH_S = 4, SH_BP = 5;
    localparam int SV_A = 6,  SV_FP = 2, SV_S = 2, SV_BP = 3;
    localparam int S_HT = SH_A + SH_FP + SH_S + SH_BP;
    localparam int S_VT = SV_A + SV_FP + SV_S + SV_BP;
    localparam logic [27:0] IDLE = 28'h6000000;

    logic        clk, reset_n, enable;
    logic [18:0] rd_addr_a, rd_addr_b;
    logic        rd_en_a, rd_en_b;
    logic [23:0] rd_data_a, rd_data_b, m1_b, junk_a;
    logic        hsync_a, vsync_a, blank_n_a, frame_start_a;
    logic        hsync_b, vsync_b, blank_n_b, frame_start_b;
    logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic [27:0] obs_a, obs_b, exp_a, exp_b;
    logic [19:0] er_a, er_b;
    logic [23:0] seed;
    int          hist [8];
    int          run_idx;
    int          n_cmp, n_fail;

    ov_7670_frame_reader u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rd_addr(rd_addr_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .hsync(hsync_a), .vsync(vsync_a), .blank_n(blank_n_a),
        .red(red_a), .green(green_a), .blue(blue_a), .frame_start(frame_start_a));

    ov_7670_frame_reader #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP), .RD_LAT(3)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rd_addr(rd_addr_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .hsync(hsync_b), .vsync(vsync_b), .blank_n(blank_n_b),
        .red(red_b), .green(green_b), .blue(blue_b), .frame_start(frame_start_b));

    assign obs_a = {blank_n_a, hsync_a, vsync_a, frame_start_a, red_a, green_a, blue_a};
    assign obs_b = {blank_n_b, hsync_b, vsync_b, frame_start_b, red_b, green_b, blue_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mem_data(input int a);
        return 24'(a) ^ seed;
    endfunction

    // Latency-1 memory answers within the cycle; latency-3 memory has two output registers
    assign rd_data_a = rd_en_a ? mem_data(int'(rd_addr_a)) : junk_a;
    always @(posedge clk) begin
        junk_a    <= 24'($urandom);
        m1_b      <= rd_en_b ? mem_data(int'(rd_addr_b)) : 24'($urandom);
        rd_data_b <= m1_b;
    end

    // History of raster positions issued per clock (-1 = nothing issued)
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) hist[i] <= -1;
            run_idx <= 0;
        end else begin
            for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= enable ? run_idx : -1;
            run_idx <= enable ? run_idx + 1 : 0;
        end
    end

    function automatic void geom(input int g, output int ha, output int hf, output int hs, output int ht,
                                 output int va, output int vf, output int vs, output int vt);
        if (g == 0) begin
            ha = 640; hf = 16; hs = 96; ht = 800; va = 480; vf = 10; vs = 2; vt = 525;
        end else begin
            ha = SH_A; hf = SH_FP; hs = SH_S; ht = S_HT; va = SV_A; vf = SV_FP; vs = SV_S; vt = S_VT;
        end
    endfunction

    function automatic logic [27:0] model_pins(input int g, input int idx);
        int ha, hf, hs, ht, va, vf, vs, vt, p, h, v;
        logic vis;
        geom(g, ha, hf, hs, ht, va, vf, vs, vt);
        if (idx < 0) return IDLE;
        p = idx % (ht * vt);
        h = p % ht;
        v = p / ht;
        vis = (h < ha) && (v < va);
        return {vis, !(h >= ha + hf && h < ha + hf + hs), !(v >= va + vf && v < va + vf + vs),
                p == 0, vis ? mem_data(v * ha + h) : 24'h0};
    endfunction

    function automatic logic [19:0] model_rd(input int g, input int idx);
        int ha, hf, hs, ht, va, vf, vs, vt, p, h, v;
        geom(g, ha, hf, hs, ht, va, vf, vs, vt);
        if (idx < 0) return 20'h0;
        p = idx % (ht * vt);
        h = p % ht;
        v = p / ht;
        if ((h < ha) && (v < va)) return {1'b1, 19'(v * ha + h)};
        return 20'h0;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp += 3;
            if (obs_a !== IDLE) begin n_fail++; $display("FAIL reset_pins_a got %h want %h", obs_a, IDLE); end
            if (obs_b !== IDLE) begin n_fail++; $display("FAIL reset_pins_b got %h want %h", obs_b, IDLE); end
            if ({rd_en_a, rd_addr_a, rd_en_b, rd_addr_b} !== 40'h0) begin
                n_fail++; $display("FAIL reset_rd got %b/%0d %b/%0d want 0", rd_en_a, rd_addr_a, rd_en_b, rd_addr_b);
            end
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            n_cmp += 3;
            if (rd_en_a !== (e >= 1) || rd_en_b !== (e >= 1)) begin
                n_fail++; $display("FAIL first_rd_en clk=%0d got %b %b want %b", e, rd_en_a, rd_en_b, e >= 1);
            end
            if (frame_start_a !== (e == 2)) begin
                n_fail++; $display("FAIL first_fs_a clk=%0d got %b want %b", e, frame_start_a, e == 2);
            end
            if (frame_start_b !== (e == 4)) begin
                n_fail++; $display("FAIL first_fs_b clk=%0d got %b want %b", e, frame_start_b, e == 4);
            end
            if (e == 1) begin
                n_cmp++;
                if (rd_addr_a !== 19'd0 || rd_addr_b !== 19'd0) begin
                    n_fail++; $display("FAIL first_addr got %0d %0d want 0", rd_addr_a, rd_addr_b);
                end
            end
            if (e == 2) begin
                n_cmp++;
                if ({blank_n_a, red_a, green_a, blue_a} !== {1'b1, mem_data(0)}) begin
                    n_fail++; $display("FAIL first_pix_a got %b/%h want 1/%h", blank_n_a, {red_a, green_a, blue_a}, mem_data(0));
                end
            end
            if (e == 4) begin
                n_cmp++;
                if ({blank_n_b, red_b, green_b, blue_b} !== {1'b1, mem_data(0)}) begin
                    n_fail++; $display("FAIL first_pix_b got %b/%h want 1/%h", blank_n_b, {red_b, green_b, blue_b}, mem_data(0));
                end
            end
            if (e < 2) begin
                n_cmp++;
                if (obs_a !== IDLE) begin n_fail++; $display("FAIL pre_pix_a clk=%0d got %h want %h", e, obs_a, IDLE); end
            end
            if (e < 4) begin
                n_cmp++;
                if (obs_b !== IDLE) begin n_fail++; $display("FAIL pre_pix_b clk=%0d got %h want %h", e, obs_b, IDLE); end
            end
        end
    endtask

    task automatic test_raster();
        int prev, rise_c, rises, hs_fall;
        logic last_blank, last_hs;
        logic [23:0] v;
        prev = -1; rise_c = -1; rises = 0; hs_fall = -1;
        last_blank = blank_n_a; last_hs = hsync_a;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            exp_a = model_pins(0, hist[1]); exp_b = model_pins(1, hist[3]);
            er_a = model_rd(0, hist[0]);    er_b = model_rd(1, hist[0]);
            n_cmp += 5;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL raster_pins_a t=%0t got %h want %h", $time, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL raster_pins_b t=%0t got %h want %h", $time, obs_b, exp_b); end
            if ({rd_en_a, rd_en_a ? rd_addr_a : 19'd0} !== er_a) begin n_fail++; $display("FAIL raster_rd_a t=%0t got %b/%0d want %h", $time, rd_en_a, rd_addr_a, er_a); end
            if ({rd_en_b, rd_en_b ? rd_addr_b : 19'd0} !== er_b) begin n_fail++; $display("FAIL raster_rd_b t=%0t got %b/%0d want %h", $time, rd_en_b, rd_addr_b, er_b); end
            if (rd_addr_a > 19'd307199) begin n_fail++; $display("FAIL addr_range_a got %0d want <=307199", rd_addr_a); end
            v = {red_a, green_a, blue_a} ^ seed;
            if (blank_n_a && !last_blank) begin
                rises++;
                rise_c = c;
                n_cmp++;
                if (v !== 24'(640 * rises)) begin n_fail++; $display("FAIL line_start got %0d want %0d", v, 640 * rises); end
            end else if (blank_n_a && prev >= 0) begin
                n_cmp++;
                if (v !== 24'(prev + 1)) begin n_fail++; $display("FAIL pixel_seq got %0d want %0d", v, prev + 1); end
            end
            if (!hsync_a && last_hs) begin
                hs_fall = c;
                if (rise_c >= 0) begin
                    n_cmp++;
                    if (c - rise_c !== 656) begin n_fail++; $display("FAIL hsync_offset got %0d want 656", c - rise_c); end
                end
            end
            if (hsync_a && !last_hs && hs_fall >= 0) begin
                n_cmp++;
                if (c - hs_fall !== 96) begin n_fail++; $display("FAIL hsync_width got %0d want 96", c - hs_fall); end
            end
            prev = blank_n_a ? int'(v) : -1;
            last_blank = blank_n_a;
            last_hs = hsync_a;
        end
    endtask

    task automatic test_frame_timing();
        int hs_low, vs_low, blank_hi, first_hs, fs_mid, max_b;
        logic found, last_hs;
        logic [23:0] last_rgb;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (frame_start_b) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL fs_timeout got none want frame_start_b"); return; end
        hs_low = 0; vs_low = 0; blank_hi = 0; first_hs = -1; fs_mid = 0; max_b = 0;
        last_hs = hsync_b; last_rgb = 24'h0;
        for (int c = 0; c < S_HT * S_VT; c++) begin
            if (c > 0) @(negedge clk);
            exp_b = model_pins(1, hist[3]);
            n_cmp++;
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL frame_pins_b t=%0t got %h want %h", $time, obs_b, exp_b); end
            if (!hsync_b) hs_low++;
            if (!vsync_b) vs_low++;
            if (blank_n_b) begin blank_hi++; last_rgb = {red_b, green_b, blue_b}; end
            if (!hsync_b && last_hs && first_hs < 0) first_hs = c;
            if (c > 0 && frame_start_b) fs_mid++;
            if (int'(rd_addr_b) > max_b) max_b = int'(rd_addr_b);
            last_hs = hsync_b;
        end
        @(negedge clk);
        n_cmp += 8;
        if (frame_start_b !== 1'b1) begin n_fail++; $display("FAIL frame_period got %b want 1 after %0d clks", frame_start_b, S_HT * S_VT); end
        if (fs_mid !== 0) begin n_fail++; $display("FAIL fs_extra got %0d want 0", fs_mid); end
        if (hs_low !== S_VT * SH_S) begin n_fail++; $display("FAIL hsync_low got %0d want %0d", hs_low, S_VT * SH_S); end
        if (vs_low !== SV_S * S_HT) begin n_fail++; $display("FAIL vsync_low got %0d want %0d", vs_low, SV_S * S_HT); end
        if (blank_hi !== SV_A * SH_A) begin n_fail++; $display("FAIL blank_hi got %0d want %0d", blank_hi, SV_A * SH_A); end
        if (first_hs !== SH_A + SH_FP) begin n_fail++; $display("FAIL hsync_start got %0d want %0d", first_hs, SH_A + SH_FP); end
        if (last_rgb !== mem_data(SV_A * SH_A - 1)) begin n_fail++; $display("FAIL last_pixel got %h want %h", last_rgb, mem_data(SV_A * SH_A - 1)); end
        if (max_b > SV_A * SH_A - 1) begin n_fail++; $display("FAIL addr_range_b got %0d want <=%0d", max_b, SV_A * SH_A - 1); end
    endtask

    task automatic test_enable_toggle();
        int fs_at;
        repeat ($urandom_range(300, 30)) @(negedge clk);
        @(posedge clk);
        #2 enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_a = model_pins(0, hist[1]); exp_b = model_pins(1, hist[3]);
            n_cmp += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL drain_pins_a k=%0d got %h want %h", k, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL drain_pins_b k=%0d got %h want %h", k, obs_b, exp_b); end
            if (k == 9) begin
                n_cmp++;
                if (obs_a !== IDLE || obs_b !== IDLE || rd_en_a || rd_en_b || rd_addr_a != 0 || rd_addr_b != 0) begin
                    n_fail++; $display("FAIL disabled_idle got %h %h %b %b want %h", obs_a, obs_b, rd_en_a, rd_en_b, IDLE);
                end
            end
        end
        @(posedge clk);
        #2 enable = 1'b1;
        fs_at = -1;
        for (int j = 0; j < S_HT * S_VT + 10; j++) begin
            @(negedge clk);
            exp_a = model_pins(0, hist[1]); exp_b = model_pins(1, hist[3]);
            er_b = model_rd(1, hist[0]);
            n_cmp += 3;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL reen_pins_a j=%0d got %h want %h", j, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL reen_pins_b j=%0d got %h want %h", j, obs_b, exp_b); end
            if ({rd_en_b, rd_en_b ? rd_addr_b : 19'd0} !== er_b) begin n_fail++; $display("FAIL reen_rd_b j=%0d got %b/%0d want %h", j, rd_en_b, rd_addr_b, er_b); end
            if (frame_start_b && fs_at < 0) begin
                fs_at = j;
                n_cmp++;
                if ({red_b, green_b, blue_b} !== mem_data(0)) begin n_fail++; $display("FAIL reen_pix0 got %h want %h", {red_b, green_b, blue_b}, mem_data(0)); end
            end
        end
        n_cmp++;
        if (fs_at !== 4) begin n_fail++; $display("FAIL reen_fs_clk got %0d want 4", fs_at); end
    endtask

    task automatic test_async_reset();
        repeat ($urandom_range(20, 5)) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp += 3;
        if (obs_a !== IDLE) begin n_fail++; $display("FAIL async_pins_a got %h want %h", obs_a, IDLE); end
        if (obs_b !== IDLE) begin n_fail++; $display("FAIL async_pins_b got %h want %h", obs_b, IDLE); end
        if ({rd_en_a, rd_addr_a, rd_en_b, rd_addr_b} !== 40'h0) begin
            n_fail++; $display("FAIL async_rd got %b/%0d %b/%0d want 0", rd_en_a, rd_addr_a, rd_en_b, rd_addr_b);
        end
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        for (int j = 0; j < S_HT * S_VT + 20; j++) begin
            @(negedge clk);
            exp_a = model_pins(0, hist[1]); exp_b = model_pins(1, hist[3]);
            er_a = model_rd(0, hist[0]);    er_b = model_rd(1, hist[0]);
            n_cmp += 4;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL rst_pins_a j=%0d got %h want %h", j, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL rst_pins_b j=%0d got %h want %h", j, obs_b, exp_b); end
            if ({rd_en_a, rd_en_a ? rd_addr_a : 19'd0} !== er_a) begin n_fail++; $display("FAIL rst_rd_a j=%0d got %b/%0d want %h", j, rd_en_a, rd_addr_a, er_a); end
            if ({rd_en_b, rd_en_b ? rd_addr_b : 19'd0} !== er_b) begin n_fail++; $display("FAIL rst_rd_b j=%0d got %b/%0d want %h", j, rd_en_b, rd_addr_b, er_b); end
            if (j == 1) begin
                n_cmp++;
                if ({rd_en_a, rd_addr_a} !== {1'b1, 19'd0}) begin n_fail++; $display("FAIL rst_restart_addr got %b/%0d want 1/0", rd_en_a, rd_addr_a); end
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        seed    = 24'($urandom);
        test_reset();
        test_raster();
        test_frame_timing();
        test_enable_toggle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
